// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, FSM state encoding and default widths
// shared by the ALU sequencing controller and its step unit.
package alu_pkg;
   localparam int DEF_WIDTH = 21;
   localparam int DEF_AMT_W = 5;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_INC = 4'h6;
   localparam logic [3:0] OP_DEC = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_ASR = 4'hA;
   localparam logic [3:0] OP_ROL = 4'hB;
   localparam logic [3:0] OP_ROR = 4'hC;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   function automatic logic is_shift(input logic [3:0] op);
      return op >= OP_SHL && op <= OP_ROR;
   endfunction
   function automatic logic is_legal(input logic [3:0] op);
      return op <= OP_ROR;
   endfunction
endpackage

// File: rtl/alu_step_unit.sv
// alu_step_unit: one combinational ALU step (arithmetic, logic, or a
// single-bit shift/rotate) with its carry / shifted-out bit.
module alu_step_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [3:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_res,
   output logic             o_carry
);
   localparam logic [WIDTH:0] ONE = 1;
   logic [WIDTH:0] w_add, w_sub, w_inc, w_dec;
   assign w_add = {1'b0, i_a} + {1'b0, i_b};
   assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + ONE;
   assign w_inc = {1'b0, i_a} + ONE;
   assign w_dec = {1'b0, i_a} - ONE;
   always_comb begin
      o_res   = '0;
      o_carry = 1'b0;
      case (i_op)
         OP_ADD:  {o_carry, o_res} = w_add;
         OP_SUB:  {o_carry, o_res} = w_sub;
         OP_AND:  o_res = i_a & i_b;
         OP_OR:   o_res = i_a | i_b;
         OP_XOR:  o_res = i_a ^ i_b;
         OP_NOT:  o_res = ~i_a;
         OP_INC:  {o_carry, o_res} = w_inc;
         OP_DEC:  {o_carry, o_res} = w_dec;
         OP_SHL:  {o_carry, o_res} = {i_a, 1'b0};
         OP_SHR:  {o_res, o_carry} = {1'b0, i_a};
         OP_ASR:  {o_res, o_carry} = {i_a[WIDTH-1], i_a};
         OP_ROL:  {o_carry, o_res} = {i_a, i_a[WIDTH-1]};
         OP_ROR:  {o_res, o_carry} = {i_a[0], i_a};
         default: ;
      endcase
   end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: accepts one ALU op per handshake, iterates shifts one bit
// per cycle, and returns a registered result with flags.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMT_W = DEF_AMT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [3:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [AMT_W-1:0] i_amt,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_zero,
   output logic             o_illegal
);
   state_t           r_state, w_state_n;
   logic [3:0]       r_op, w_op_n;
   logic [AMT_W-1:0] r_cnt, w_cnt_n;
   logic [WIDTH-1:0] r_result, w_result_n, w_step;
   logic             r_carry, r_zero, r_illegal, w_carry_n, w_zero_n, w_illegal_n, w_step_c, w_idle;
   assign w_idle      = r_state == S_IDLE;
   assign o_in_ready  = w_idle;
   assign o_out_valid = r_state == S_DONE;
   assign o_result    = r_result;
   assign o_carry     = r_carry;
   assign o_zero      = r_zero;
   assign o_illegal   = r_illegal;
   // The first shift step is taken on the accepting edge, so the result
   // register doubles as the shift accumulator during RUN.
   alu_step_unit #(.WIDTH(WIDTH)) u_step (
      .i_op    (w_idle ? i_op : r_op),
      .i_a     (w_idle ? i_a : r_result),
      .i_b     (i_b),
      .o_res   (w_step),
      .o_carry (w_step_c)
   );
   always_comb begin
      w_state_n   = r_state;
      w_op_n      = r_op;
      w_cnt_n     = r_cnt;
      w_result_n  = r_result;
      w_carry_n   = r_carry;
      w_zero_n    = r_zero;
      w_illegal_n = r_illegal;
      case (r_state)
         S_IDLE: if (i_in_valid) begin
            w_op_n      = i_op;
            w_cnt_n     = i_amt - 1'b1;
            w_illegal_n = !is_legal(i_op);
            w_result_n  = (is_shift(i_op) && ~|i_amt) ? i_a : w_step;
            w_carry_n   = (is_shift(i_op) && ~|i_amt) ? 1'b0 : w_step_c;
            w_zero_n    = w_result_n == '0;
            w_state_n   = (is_shift(i_op) && |i_amt[AMT_W-1:1]) ? S_RUN : S_DONE;
         end
         S_RUN: begin
            w_cnt_n    = r_cnt - 1'b1;
            w_result_n = w_step;
            w_carry_n  = w_step_c;
            w_zero_n   = w_step == '0;
            w_state_n  = (r_cnt == AMT_W'(1)) ? S_DONE : S_RUN;
         end
         S_DONE:  w_state_n = i_out_ready ? S_IDLE : S_DONE;
         default: w_state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_op      <= OP_ADD;
         r_cnt     <= '0;
         r_result  <= '0;
         r_carry   <= 1'b0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_op      <= w_op_n;
         r_cnt     <= w_cnt_n;
         r_result  <= w_result_n;
         r_carry   <= w_carry_n;
         r_zero    <= w_zero_n;
         r_illegal <= w_illegal_n;
      end
   end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vectors with hand-computed results, latency and
// handshake checks for the ALU sequencing controller.
module tb_alu_seq_ctrl;
   import alu_pkg::*;
   logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic [3:0]  op = 0;
   logic [20:0] a = 0, b = 0;
   logic [4:0]  amt = 0;
   logic        in_ready, out_valid, carry, zero, illegal;
   logic [20:0] result;
   int          total = 0, bad = 0;
   always #5 clk = ~clk;
   alu_seq_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_op(op), .i_a(a), .i_b(b), .i_amt(amt), .o_out_valid(out_valid),
      .i_out_ready(out_ready), .o_result(result), .o_carry(carry), .o_zero(zero),
      .o_illegal(illegal)
   );
   task automatic issue(input logic [3:0] o, input logic [20:0] aa, input logic [20:0] bb, input logic [4:0] n);
      int w = 0;
      while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b want=1", in_ready); end
      op = o; a = aa; b = bb; amt = n; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
   endtask
   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
   endtask
   task automatic release_out();
      out_ready = 1; @(posedge clk); #1; out_ready = 0;
   endtask
   task automatic test_reset();
      rst_n = 0; repeat (3) @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if ({result, carry, zero, illegal} !== 24'h0) begin bad++; $display("FAIL rst_regs got=%h/%b%b%b want=0/000", result, carry, zero, illegal); end
      rst_n = 1; @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
   endtask
   task automatic test_single();
      int lat;
      issue(OP_ADD, 21'h1FFFFF, 21'h000001, 0); wait_done(lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL add_lat got=%0d want=1", lat); end
      total++; if ({result, carry, zero, illegal} !== {21'h0, 3'b110}) begin bad++; $display("FAIL add got=%h/%b%b%b want=000000/110", result, carry, zero, illegal); end
      release_out();
      issue(OP_SUB, 21'd5, 21'd7, 0); wait_done(lat);
      total++; if ({result, carry, zero} !== {21'h1FFFFE, 2'b00}) begin bad++; $display("FAIL sub got=%h/%b%b want=1ffffe/00", result, carry, zero); end
      release_out();
      issue(OP_DEC, 21'h0, 21'h0, 0); wait_done(lat);
      total++; if ({result, carry, zero} !== {21'h1FFFFF, 2'b10}) begin bad++; $display("FAIL dec got=%h/%b%b want=1fffff/10", result, carry, zero); end
      release_out();
      issue(OP_INC, 21'h1FFFFF, 21'h0, 0); wait_done(lat);
      total++; if ({result, carry, zero} !== {21'h0, 2'b11}) begin bad++; $display("FAIL inc got=%h/%b%b want=000000/11", result, carry, zero); end
      release_out();
      issue(OP_XOR, 21'h0F0F0F, 21'h00FF00, 0); wait_done(lat);
      total++; if ({result, carry} !== {21'h0FF00F, 1'b0}) begin bad++; $display("FAIL xor got=%h/%b want=0ff00f/0", result, carry); end
      release_out();
      issue(OP_NOT, 21'h0, 21'h1, 0); wait_done(lat);
      total++; if ({result, carry, zero} !== {21'h1FFFFF, 2'b00}) begin bad++; $display("FAIL not got=%h/%b%b want=1fffff/00", result, carry, zero); end
      release_out();
   endtask
   task automatic test_asr_ignore();
      int lat = 1;
      issue(OP_ASR, 21'h100000, 21'h0, 4);
      while (!out_valid && lat < 50) begin
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL run_in_ready got=%b want=0", in_ready); end
         op = OP_ADD; a = 21'h7; in_valid = lat[0];
         @(posedge clk); #1; lat++;
      end
      in_valid = 0;
      total++; if (lat !== 4) begin bad++; $display("FAIL asr_lat got=%0d want=4", lat); end
      total++; if ({result, carry, zero} !== {21'h1F0000, 2'b00}) begin bad++; $display("FAIL asr got=%h/%b%b want=1f0000/00", result, carry, zero); end
      release_out();
   endtask
   task automatic test_shifts();
      int lat;
      issue(OP_ROL, 21'h100000, 21'h0, 3); wait_done(lat);
      total++; if ({result, carry, lat} !== {21'h000004, 1'b0, 32'd3}) begin bad++; $display("FAIL rol got=%h/%b lat=%0d want=000004/0 lat=3", result, carry, lat); end
      release_out();
      issue(OP_SHL, 21'h000001, 21'h0, 25); wait_done(lat);
      total++; if ({result, carry, zero, lat} !== {21'h0, 2'b01, 32'd25}) begin bad++; $display("FAIL shl25 got=%h/%b%b lat=%0d want=000000/01 lat=25", result, carry, zero, lat); end
      release_out();
      issue(OP_ASR, 21'h1ABCDE, 21'h0, 0); wait_done(lat);
      total++; if ({result, carry, lat} !== {21'h1ABCDE, 1'b0, 32'd1}) begin bad++; $display("FAIL asr0 got=%h/%b lat=%0d want=1abcde/0 lat=1", result, carry, lat); end
      release_out();
      issue(OP_SHR, 21'h000003, 21'h0, 1); wait_done(lat);
      total++; if ({result, carry, lat} !== {21'h000001, 1'b1, 32'd1}) begin bad++; $display("FAIL shr1 got=%h/%b lat=%0d want=000001/1 lat=1", result, carry, lat); end
      release_out();
      issue(OP_ROR, 21'h1ABCDE, 21'h0, 21); wait_done(lat);
      total++; if ({result, carry, lat} !== {21'h1ABCDE, 1'b1, 32'd21}) begin bad++; $display("FAIL ror21 got=%h/%b lat=%0d want=1abcde/1 lat=21", result, carry, lat); end
      release_out();
      issue(OP_ASR, 21'h100000, 21'h0, 31); wait_done(lat);
      total++; if ({result, carry} !== {21'h1FFFFF, 1'b1}) begin bad++; $display("FAIL asr31 got=%h/%b want=1fffff/1", result, carry); end
      release_out();
   endtask
   task automatic test_back_to_back();
      int lat;
      issue(OP_ADD, 21'd3, 21'd4, 0); wait_done(lat);
      repeat (3) begin
         total++; if ({out_valid, result, carry, zero} !== {1'b1, 21'd7, 2'b00}) begin bad++; $display("FAIL hold got=%b/%h/%b%b want=1/000007/00", out_valid, result, carry, zero); end
         @(posedge clk); #1;
      end
      release_out();
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL release got=%b%b want=10", in_ready, out_valid); end
      issue(OP_AND, 21'h1F00F0, 21'h0F0FF0, 0); wait_done(lat);
      total++; if ({result, lat} !== {21'h0F00F0, 32'd1}) begin bad++; $display("FAIL b2b got=%h lat=%0d want=0f00f0 lat=1", result, lat); end
      release_out();
   endtask
   task automatic test_reset_mid();
      issue(OP_SHR, 21'h1FFFFF, 21'h0, 10);
      @(posedge clk); #1;
      rst_n = 0; @(posedge clk); #1;
      total++; if ({out_valid, result, carry, illegal} !== 24'h0) begin bad++; $display("FAIL midrst got=%b/%h/%b%b want=0/000000/00", out_valid, result, carry, illegal); end
      rst_n = 1; @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
      repeat (12) @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_dropped got=%b want=0", out_valid); end
   endtask
   task automatic test_illegal();
      int lat;
      issue(4'hF, 21'h12345, 21'h54321, 3); wait_done(lat);
      total++; if ({result, carry, zero, illegal, lat} !== {21'h0, 3'b011, 32'd1}) begin bad++; $display("FAIL illegal got=%h/%b%b%b lat=%0d want=000000/011 lat=1", result, carry, zero, illegal, lat); end
      release_out();
      issue(OP_ADD, 21'd1, 21'd1, 0); wait_done(lat);
      total++; if ({result, illegal} !== {21'd2, 1'b0}) begin bad++; $display("FAIL illegal_clear got=%h/%b want=000002/0", result, illegal); end
      release_out();
   endtask
   initial begin
      test_reset();
      test_single();
      test_asr_ignore();
      test_shifts();
      test_back_to_back();
      test_reset_mid();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the 21-bit ALU operation units. It accepts one operation per handshake, runs single-cycle ops (add/sub/logic/inc/dec) in one step, and iterates the one-bit shift/rotate units for multi-bit shift amounts. It returns a registered result with carry and zero flags over a valid/ready output handshake. It sits between the instruction decode stage and the register-file writeback.

## Interface
- `WIDTH`, 21: datapath width; all operand and result widths follow it.
- `AMT_W`, 5: shift-amount width; amounts 0..31.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  controller can accept; high only in IDLE.
- `op`  in  4  opcode (encoding in `alu_pkg`).
- `a`, `b`  in  WIDTH  operands; `b` is ignored for unary and shift ops.
- `amt`  in  AMT_W  shift/rotate count.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes result.
- `result`  out  WIDTH  registered result.
- `carry`  out  1  carry/borrow/overflow/shifted-out bit.
- `zero`  out  1  result == 0.
- `illegal`  out  1  opcode was unrecognised.

## Operation
- Opcodes: ADD, SUB, AND, OR, XOR, NOT, INC, DEC, SHL, SHR, ASR, ROL, ROR. The remaining codes are illegal.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, capture `op`, `a`, `b`, `amt`.
    - Single-cycle op, or shift op with `amt`=0: go to DONE.
    - Otherwise: go to RUN with acc=`a`, cnt=`amt`.
  - RUN: apply one step per cycle (SHL/SHR logical by 1; ASR sign-fill; ROL/ROR rotate by 1) and decrement cnt. When the step with cnt=1 completes, go to DONE.
  - DONE: `out_valid`=1, outputs held stable. On `out_ready`, go to IDLE.
- Arithmetic rules:
  - ADD: carry = CLA carry-out.
  - SUB: computed as A+~B+1; carry = carry-out, so 1 means no borrow.
  - INC/DEC: 22-bit result. `carry` = bit 21, so INC 0x1FFFFF gives 0 with carry 1, and DEC 0 gives 0x1FFFFF with carry 1.
  - Logic ops: carry = 0.
  - Shifts/rotates: carry = bit shifted out, or wrapped, on the final step. With `amt`=0, result = `a` and carry = 0.
  - `amt` ≥ 21 is iterated literally: SHL/SHR give 0, ASR gives full sign fill, and rotate by 21 returns `a`.
- Illegal op: go to DONE with result=0, carry=0, zero=1, `illegal`=1.
- `in_valid` outside IDLE is ignored. There is no queueing.

## Timing
- Reset: state IDLE; `result`=0; `carry`=0; `zero`=0; `illegal`=0; `out_valid`=0; `in_ready`=1 from the first cycle after reset release.
- Latency is measured in rising edges from the accepting edge (in_valid & in_ready) to the first edge where `out_valid` is high.
  - Single-cycle ops, `amt`=0 shifts, and illegal ops: 1.
  - Shifts with `amt`≥1: `amt`.
- `out_valid` stays high until the edge where `out_ready` is sampled high. `in_ready` rises the following cycle, so throughput is at most one op per 2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs except `in_ready` from state.
- `rst_n` low in any state (including mid-RUN or DONE) drops the operation and restores the reset values at the next edge.

## Structure
- `alu_pkg`: opcode localparams, FSM state encoding, `WIDTH`/`AMT_W` defaults.
- Sub-module `alu_step_unit`: combinational block. It instantiates the existing CLA, logic, inc/dec, shift and rotate units and selects one step result plus carry by opcode. The controller FSM and registers wrap it.

## Test plan
- ADD a=0x1FFFFF b=0x000001 → result 0x000000, carry 1, zero 1, `out_valid` 1 edge after accept.
- SUB a=5 b=7 → result 0x1FFFFE, carry 0, zero 0; DEC a=0 → 0x1FFFFF, carry 1.
- ASR a=0x100000 amt=4 → result 0x1F0000, carry 0, `out_valid` at edge 4. `in_valid` pulses during RUN are ignored and `in_ready` stays 0.
- ROL a=0x100000 amt=3 → 0x000004, carry 0; SHL a=0x000001 amt=25 → 0x000000, zero 1, latency 25.
- Backpressure: hold `out_ready`=0 for 3 cycles after ADD → `result`/flags stable, `out_valid` high throughout. Release → IDLE next cycle, and a back-to-back request is accepted.
- `rst_n` low at RUN cycle 2 of SHR amt=10 → next edge `out_valid`=0, result 0, `in_ready`=1 after release. Illegal opcode 0xF → `illegal`=1, result 0, latency 1.
